instruction_fetch: RTL

Fetch stage of the 16-bit single-cycle CPU: holds the program counter, owns the instruction memory, and presents the current instruction and its 4-bit opcode to the control unit and datapath. It resolves BEQ/BNE using the Branch control signal and the ALU Zero flag, and steps the PC once per clock while running. A small run/halt state machine plus a load port let the bench preload programs and stop execution cleanly.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/instruction_memory.sv | 26 ++
 rtl/instruction_fetch.sv | 112 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-cycle CPU: word width,
// opcode constants used by fetch and the control unit, fetch FSM states.
package cpu_pkg;

    localparam int WORD_W = 16;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_HALT = 4'b0111;
    localparam logic [3:0] OP_BNE  = 4'b1110;
    localparam logic [3:0] OP_BEQ  = 4'b1111;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_RUN    = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_t;

    // Branch displacement in bytes: signed word offset doubled.
    function automatic logic [WORD_W-1:0] branch_offset(input logic [7:0] imm);
        return {{7{imm[7]}}, imm, 1'b0};
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Instruction store: synchronous write port for program loading,
// asynchronous read port for zero-latency fetch. Contents survive reset.
module instruction_memory
    import cpu_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Program load write
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, branch resolution, run/halt control,
// retire counter and out-of-range fault detection.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int          IMEM_DEPTH = 128,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Start,
    input  logic                          i_LoadEn,
    input  logic [$clog2(IMEM_DEPTH)-1:0] i_LoadAddr,
    input  logic [WORD_W-1:0]             i_LoadData,
    input  logic                          i_Branch,
    input  logic                          i_Zero,
    output logic [WORD_W-1:0]             o_PC,
    output logic [WORD_W-1:0]             o_Instruction,
    output logic [3:0]                    o_Opcode,
    output logic                          o_InstrValid,
    output logic                          o_Halted,
    output logic                          o_Fault,
    output logic [15:0]                   o_RetireCount
);

    localparam int AW = $clog2(IMEM_DEPTH);

    fetch_state_t      r_state, w_next_state;
    logic [WORD_W-1:0] r_pc;
    logic [15:0]       r_retire;
    logic              r_fault;

    logic [WORD_W-1:0] w_rdata, w_instr, w_pc_seq, w_next_pc;
    logic [3:0]        w_opcode;
    logic              w_in_range, w_run, w_taken, w_is_halt, w_load_we;

    // Word index beyond the array means the PC ran off the program
    assign w_in_range = ({1'b0, r_pc[15:1]} < 16'(IMEM_DEPTH));
    assign w_run      = (r_state == FS_RUN);
    assign w_instr    = w_in_range ? w_rdata : '0;
    assign w_opcode   = w_instr[15:12];
    assign w_is_halt  = (w_opcode == OP_HALT);

    // BEQ comes in via Branch; BNE is decoded here since control drives Branch=0 for it
    assign w_taken   = (i_Branch & i_Zero) | ((w_opcode == OP_BNE) & ~i_Zero);
    assign w_pc_seq  = r_pc + 16'd2;
    assign w_next_pc = w_taken ? (w_pc_seq + branch_offset(w_instr[7:0])) : w_pc_seq;

    instruction_memory #(.DEPTH(IMEM_DEPTH), .AW(AW)) u_imem (
        .i_clk   (i_Clock),
        .i_we    (w_load_we),
        .i_waddr (i_LoadAddr),
        .i_wdata (i_LoadData),
        .i_raddr (r_pc[AW:1]),
        .o_rdata (w_rdata)
    );

    // FSM state register
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) r_state <= FS_IDLE;
        else         r_state <= w_next_state;
    end

    // FSM next-state: leave RUN on HALT fetch or on running off the memory
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FS_IDLE:   if (i_Start) w_next_state = FS_RUN;
            FS_RUN:    if (!w_in_range || w_is_halt) w_next_state = FS_HALTED;
            FS_HALTED: w_next_state = FS_HALTED;
            default:   w_next_state = FS_IDLE;
        endcase
    end

    // FSM outputs: status flags and load gating
    always_comb begin
        o_InstrValid = 1'b0;
        o_Halted     = 1'b0;
        w_load_we    = 1'b0;
        case (r_state)
            FS_IDLE:   w_load_we    = i_LoadEn;
            FS_RUN:    o_InstrValid = w_in_range;
            FS_HALTED: o_Halted     = 1'b1;
            default:   ;
        endcase
    end

    // PC advances every RUN edge except on HALT or out-of-range fetch
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)                            r_pc <= RESET_PC;
        else if (w_run && w_in_range && !w_is_halt) r_pc <= w_next_pc;
    end

    // Retire counter: every real instruction executed in RUN, HALT included
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)                  r_retire <= '0;
        else if (w_run && w_in_range) r_retire <= r_retire + 16'd1;
    end

    // Sticky fault once the PC leaves the instruction memory in RUN
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)                   r_fault <= 1'b0;
        else if (w_run && !w_in_range) r_fault <= 1'b1;
    end

    assign o_PC          = r_pc;
    assign o_Instruction = w_instr;
    assign o_Opcode      = w_opcode;
    assign o_Fault       = r_fault;
    assign o_RetireCount = r_retire;

endmodule
